// File: rtl/alu_shift_seq.sv
// alu_shift_seq
// Multi-cycle sequencer for x86 shift/rotate-by-count (Grp2 with CL/imm8).
// It borrows the shared single-bit ALU shift path for one step per cycle.
// The running carry is fed back through alu_flags[0], and the flags are
// built here because the ALU produces none for shift modes.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   start             launch request, accepted only in IDLE
//   mode, bit16       shift op (8 ROL, 9 ROR, A RCL, B RCR, C/E SHL, D SHR,
//                     F SAR; 0-7 behave as count 0) and operand width
//   op1, count        operand and shift count (count masked by CNT_MASK)
//   flags_in          flags at launch
//   busy              high while the sequencer owns the ALU (RUN)
//   done              one-cycle pulse, result/flags_out valid
//   result, flags_out final value and flags, held until the next completion
//   alu_mode, alu_op1, alu_bit16, alu_flags   ALU drive, zero outside RUN
//   alu_value         single-step result returned by the ALU
module alu_shift_seq #(
    parameter logic [4:0] CNT_MASK = 5'h1F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic        bit16,
    input  logic [15:0] op1,
    input  logic [7:0]  count,
    input  logic [11:0] flags_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [11:0] flags_out,
    output logic [3:0]  alu_mode,
    output logic [15:0] alu_op1,
    output logic        alu_bit16,
    output logic [11:0] alu_flags,
    input  logic [15:0] alu_value
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  mode_q;
    logic        bit16_q;
    logic [15:0] w_q;
    logic [11:0] f_q;
    logic [4:0]  n_q;
    logic        msb0_q;     // msb of the original operand, needed for SHR OF

    logic [4:0]  n_start;
    logic        zero_cnt;
    logic        is_rol, is_ror, is_rcl, is_rcr, is_shl, is_shr, is_sar;
    logic        msb_old, msb_new, step_cf;
    logic [15:0] w_nxt;
    logic        r_msb, r_msb1, r_zero, of_bit;
    logic [11:0] fin_flags;

    // The mask is 5 bits wide, so the top bits of count never matter.
    logic unused;
    assign unused = ^count[7:5];

    assign n_start  = count[4:0] & CNT_MASK;
    assign zero_cnt = (n_start == 5'd0) || !mode[3];

    always_comb begin
        is_rol = (mode_q == 4'h8);
        is_ror = (mode_q == 4'h9);
        is_rcl = (mode_q == 4'hA);
        is_rcr = (mode_q == 4'hB);
        is_shl = (mode_q == 4'hC) || (mode_q == 4'hE);
        is_shr = (mode_q == 4'hD);
        is_sar = (mode_q == 4'hF);
    end

    // One step: in 8-bit mode only the low byte follows the ALU.
    always_comb begin
        w_nxt   = bit16_q ? alu_value : {w_q[15:8], alu_value[7:0]};
        msb_old = bit16_q ? w_q[15] : w_q[7];
        msb_new = bit16_q ? alu_value[15] : alu_value[7];
        step_cf = f_q[0];
        if (is_shl || is_rcl)
            step_cf = msb_old;
        else if (is_shr || is_sar || is_rcr)
            step_cf = w_q[0];
        else if (is_rol)
            step_cf = alu_value[0];
        else if (is_ror)
            step_cf = msb_new;
    end

    // Final flags, evaluated on the last RUN step from the value being written.
    always_comb begin
        r_msb  = bit16_q ? w_nxt[15] : w_nxt[7];
        r_msb1 = bit16_q ? w_nxt[14] : w_nxt[6];
        r_zero = bit16_q ? (w_nxt == 16'h0000) : (w_nxt[7:0] == 8'h00);
        of_bit = 1'b0;
        if (is_shl || is_rol || is_rcl)
            of_bit = r_msb ^ step_cf;
        else if (is_ror || is_rcr)
            of_bit = r_msb ^ r_msb1;
        else if (is_shr)
            of_bit = msb0_q;

        fin_flags     = f_q;
        fin_flags[0]  = step_cf;
        fin_flags[1]  = 1'b1;
        fin_flags[3]  = 1'b0;
        fin_flags[5]  = 1'b0;
        fin_flags[11] = of_bit;
        if (is_shl || is_shr || is_sar) begin
            fin_flags[7] = r_msb;
            fin_flags[6] = r_zero;
            fin_flags[2] = ~^w_nxt[7:0];
            fin_flags[4] = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_cnt ? DONE : RUN;
            RUN:     if (n_q == 5'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= 4'h0;
            bit16_q   <= 1'b0;
            w_q       <= 16'h0000;
            f_q       <= 12'h000;
            n_q       <= 5'd0;
            msb0_q    <= 1'b0;
            result    <= 16'h0000;
            flags_out <= 12'h002;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    mode_q  <= mode;
                    bit16_q <= bit16;
                    w_q     <= op1;
                    f_q     <= flags_in;
                    n_q     <= n_start;
                    msb0_q  <= bit16 ? op1[15] : op1[7];
                    if (zero_cnt) begin
                        result    <= op1;
                        flags_out <= flags_in;
                    end
                end
                RUN: begin
                    w_q    <= w_nxt;
                    f_q[0] <= step_cf;
                    n_q    <= n_q - 5'd1;
                    if (n_q == 5'd1) begin
                        result    <= w_nxt;
                        flags_out <= fin_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        alu_mode  = 4'h0;
        alu_op1   = 16'h0000;
        alu_bit16 = 1'b0;
        alu_flags = 12'h000;
        if (state == RUN) begin
            alu_mode  = mode_q;
            alu_op1   = w_q;
            alu_bit16 = bit16_q;
            alu_flags = f_q;
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Testbench for alu_shift_seq: models the single-step ALU, drives directed
// and random shift/rotate operations, and scores results against a
// closed-form reference of x86 shift semantics.
module tb_alu_shift_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mode;
    logic        bit16;
    logic [15:0] op1;
    logic [7:0]  count;
    logic [11:0] flags_in;
    logic        busy, done;
    logic [15:0] result;
    logic [11:0] flags_out;
    logic [3:0]  alu_mode;
    logic [15:0] alu_op1;
    logic        alu_bit16;
    logic [11:0] alu_flags;
    logic [15:0] alu_value;

    alu_shift_seq dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode), .bit16(bit16),
        .op1(op1), .count(count), .flags_in(flags_in), .busy(busy), .done(done),
        .result(result), .flags_out(flags_out), .alu_mode(alu_mode),
        .alu_op1(alu_op1), .alu_bit16(alu_bit16), .alu_flags(alu_flags),
        .alu_value(alu_value)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic [11:0] fl;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Single-bit ALU shift path; in 8-bit mode the upper byte is garbage.
    function automatic logic [15:0] alu_step(input logic [3:0] m, input logic [15:0] v,
                                             input logic b16, input logic c);
        logic [7:0] b;
        b = v[7:0];
        if (b16) begin
            case (m)
                4'h8: return {v[14:0], v[15]};
                4'h9: return {v[0], v[15:1]};
                4'hA: return {v[14:0], c};
                4'hB: return {c, v[15:1]};
                4'hC, 4'hE: return {v[14:0], 1'b0};
                4'hD: return {1'b0, v[15:1]};
                4'hF: return {v[15], v[15:1]};
                default: return v;
            endcase
        end else begin
            case (m)
                4'h8: return {~v[15:8], b[6:0], b[7]};
                4'h9: return {~v[15:8], b[0], b[7:1]};
                4'hA: return {~v[15:8], b[6:0], c};
                4'hB: return {~v[15:8], c, b[7:1]};
                4'hC, 4'hE: return {~v[15:8], b[6:0], 1'b0};
                4'hD: return {~v[15:8], 1'b0, b[7:1]};
                4'hF: return {~v[15:8], b[7], b[7:1]};
                default: return v;
            endcase
        end
    endfunction

    always_comb alu_value = alu_step(alu_mode, alu_op1, alu_bit16, alu_flags[0]);

    // Closed-form reference: whole-count shifts/rotates on wide integers.
    function automatic void model(input logic [3:0] m, input logic b16, input logic [15:0] v0,
                                  input int n, input logic [11:0] fi,
                                  output logic [15:0] r, output logic [11:0] fo);
        int w, k;
        logic [63:0] msk, v, x, xm, rx, rr, t;
        longint sv;
        logic cf, of, msb_r;
        w   = b16 ? 16 : 8;
        msk = (64'd1 << w) - 64'd1;
        v   = {48'd0, v0} & msk;
        if (n == 0 || m < 4'h8) begin
            r  = v0;
            fo = fi;
            return;
        end
        rr = 64'd0;
        cf = 1'b0;
        sv = b16 ? longint'($signed(v0)) : longint'($signed(v0[7:0]));
        x  = (64'(fi[0]) << w) | v;
        xm = (64'd1 << (w + 1)) - 64'd1;
        case (m)
            4'h8: begin k = n % w; rr = ((v << k) | (v >> (w - k))) & msk; cf = rr[0]; end
            4'h9: begin k = n % w; rr = ((v >> k) | (v << (w - k))) & msk; cf = rr[w-1]; end
            4'hA: begin k = n % (w + 1); rx = ((x << k) | (x >> (w + 1 - k))) & xm;
                        rr = rx & msk; cf = rx[w]; end
            4'hB: begin k = n % (w + 1); rx = ((x >> k) | (x << (w + 1 - k))) & xm;
                        rr = rx & msk; cf = rx[w]; end
            4'hC, 4'hE: begin rr = (v << n) & msk; t = (v << n) >> w; cf = t[0]; end
            4'hD: begin rr = v >> n; t = v >> (n - 1); cf = t[0]; end
            default: begin rr = 64'(sv >>> n) & msk; t = 64'(sv >>> (n - 1)); cf = t[0]; end
        endcase
        msb_r = rr[w-1];
        case (m)
            4'h8, 4'hA, 4'hC, 4'hE: of = msb_r ^ cf;
            4'h9, 4'hB:             of = rr[w-1] ^ rr[w-2];
            4'hD:                   of = v[w-1];
            default:                of = 1'b0;
        endcase
        fo     = fi;
        fo[0]  = cf;
        fo[1]  = 1'b1;
        fo[3]  = 1'b0;
        fo[5]  = 1'b0;
        fo[11] = of;
        if (m >= 4'hC) begin
            fo[7] = msb_r;
            fo[6] = (rr == 64'd0);
            fo[2] = ~^rr[7:0];
            fo[4] = 1'b0;
        end
        r = b16 ? rr[15:0] : {v0[15:8], rr[7:0]};
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e.res});
                    chk("flags_out", {20'd0, flags_out}, {20'd0, e.fl});
                    chk("latency", cyc, e.due);
                    chk("busy_at_done", {31'd0, busy}, 32'd0);
                end
            end
            if (!busy)
                chk("alu_idle_zero", {alu_mode, alu_op1, alu_bit16, alu_flags}, 32'd0);
        end
    end

    task automatic scramble();
        mode     = 4'($urandom);
        bit16    = 1'($urandom);
        op1      = 16'($urandom);
        count    = 8'($urandom);
        flags_in = 12'($urandom);
    endtask

    task automatic run_op(input logic [3:0] m, input logic b16, input logic [15:0] v,
                          input logic [7:0] c, input logic [11:0] fi,
                          output logic [15:0] got_r, output logic [11:0] got_f,
                          output int bc, output logic [31:0] cft);
        int n, neff, t;
        logic [15:0] er;
        logic [11:0] ef;
        n    = int'(c[4:0]);
        neff = (m < 4'h8) ? 0 : n;
        model(m, b16, v, n, fi, er, ef);
        @(negedge clock);
        start = 1'b1; mode = m; bit16 = b16; op1 = v; count = c; flags_in = fi;
        q.push_back('{er, ef, cyc + 1 + neff});
        @(negedge clock);
        start = 1'b0;
        scramble();
        bc  = 0;
        cft = 32'd0;
        t   = 0;
        while (!done && t < 40) begin
            if (busy) begin
                if (bc < 32) cft[bc] = alu_flags[0];
                bc++;
            end
            // Launch attempts while busy must be ignored.
            start = busy && ($urandom_range(0, 3) == 0);
            scramble();
            @(negedge clock);
            t++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        got_r = result;
        got_f = flags_out;
        chk("busy_cycles", bc, neff);
        // A start in the DONE cycle must also be ignored.
        start = 1'($urandom);
        scramble();
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] gr;
        logic [11:0] gf;
        int bc, dcnt;
        logic [31:0] cft;
        logic [3:0] rm;
        logic [7:0] rc;

        reset = 1'b1;
        start = 1'b0;
        mode = 4'h0; bit16 = 1'b0; op1 = 16'h0; count = 8'h0; flags_in = 12'h0;
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {20'd0, flags_out}, 32'h002);
        chk("rst_alu", {alu_mode, alu_op1, alu_bit16, alu_flags}, 32'd0);
        reset = 1'b0;

        run_op(4'hC, 1'b1, 16'h8001, 8'd1, 12'h002, gr, gf, bc, cft);
        chk("shl_res", {16'd0, gr}, 32'h0002);
        chk("shl_flags", {20'd0, gf}, 32'h803);

        run_op(4'h9, 1'b0, 16'h1201, 8'd3, 12'h0C4, gr, gf, bc, cft);
        chk("ror_res", {16'd0, gr}, 32'h1220);
        chk("ror_flags", {20'd0, gf}, 32'h0C6);

        run_op(4'hA, 1'b0, 16'h0080, 8'd2, 12'h002, gr, gf, bc, cft);
        chk("rcl_cf_trace", {30'd0, cft[1:0]}, 32'h2);
        chk("rcl_res", {16'd0, gr}, 32'h0001);
        chk("rcl_flags", {20'd0, gf}, 32'h002);

        run_op(4'hF, 1'b1, 16'h8000, 8'd15, 12'h002, gr, gf, bc, cft);
        chk("sar_res", {16'd0, gr}, 32'hFFFF);
        chk("sar_flags", {20'd0, gf}, 32'h086);
        chk("sar_busy", bc, 15);

        run_op(4'hD, 1'b1, 16'h1234, 8'h20, 12'h8C3, gr, gf, bc, cft);
        chk("cnt0_res", {16'd0, gr}, 32'h1234);
        chk("cnt0_flags", {20'd0, gf}, 32'h8C3);

        // Reset on the fourth RUN cycle of a 10-step SHL.
        @(negedge clock);
        start = 1'b1; mode = 4'hC; bit16 = 1'b1; op1 = 16'hABCD; count = 8'd10; flags_in = 12'h002;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_flags", {20'd0, flags_out}, 32'h002);
        dcnt = 0;
        repeat (14) begin
            if (done) dcnt++;
            @(negedge clock);
        end
        chk("abort_no_done", dcnt, 0);

        run_op(4'hC, 1'b1, 16'hABCD, 8'd10, 12'h002, gr, gf, bc, cft);
        chk("post_reset_res", {16'd0, gr}, 32'h3400);

        for (int i = 0; i < 150; i++) begin
            rm = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 7)) : 4'(8 + $urandom_range(0, 7));
            rc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17));
            run_op(rm, 1'($urandom), 16'($urandom), rc, 12'($urandom), gr, gf, bc, cft);
        end

        repeat (3) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
